// File: rtl/sdram_frame_sched.sv
// Double-buffered frame scheduler: arbitrates write and read SDRAM bursts
// between two frame buffers, tracking per-direction offsets and buffer swaps.
module sdram_frame_sched #(
  parameter logic [9:0]  BURST_LEN   = 10'd256,
  parameter logic [20:0] FRAME_WORDS = 21'd518400,
  parameter logic [20:0] BANK1_BASE  = 21'd524288,
  parameter logic [10:0] FIFO_DEPTH  = 11'd1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic [10:0] wr_fifo_level,
  input  logic [10:0] rd_fifo_level,
  input  logic        wr_frame_start,
  input  logic        rd_frame_start,
  output logic        sdram_wr_req,
  output logic        sdram_rd_req,
  output logic [20:0] sdram_wr_addr,
  output logic [20:0] sdram_rd_addr,
  output logic [9:0]  wr_burst_len,
  output logic [9:0]  rd_burst_len,
  input  logic        sdram_wr_ack,
  input  logic        sdram_rd_ack,
  output logic        wr_buf,
  output logic        rd_buf,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t      state;
  logic [10:0] ack_cnt;
  logic [20:0] wr_off;
  logic [20:0] rd_off;
  logic        full_buf;
  logic        wr_pend;
  logic        rd_pend;
  logic        last_wr;

  logic        wr_need;
  logic        rd_need;
  logic        wr_clr;
  logic        rd_clr;
  logic        last_cnt;
  logic        pick_wr;
  logic [20:0] wr_off_inc;
  logic [20:0] rd_off_inc;
  logic        wr_wrap;
  logic        rd_wrap;
  logic        rd_sel_buf;
  logic [20:0] wr_start_addr;
  logic [20:0] rd_start_addr;

  assign wr_burst_len = BURST_LEN;
  assign rd_burst_len = BURST_LEN;
  assign fsm_state    = state;

  assign wr_need  = wr_fifo_level >= {1'b0, BURST_LEN};
  assign rd_need  = rd_fifo_level <= (FIFO_DEPTH - {1'b0, BURST_LEN});
  // A frame-start pulse arriving this cycle counts as already pending.
  assign wr_clr   = wr_pend | wr_frame_start;
  assign rd_clr   = rd_pend | rd_frame_start;
  assign last_cnt = ack_cnt == {1'b0, BURST_LEN - 10'd1};
  // Round-robin: on contention serve the type not served last.
  assign pick_wr  = wr_need && (!rd_need || !last_wr);

  assign wr_off_inc = wr_off + {11'd0, BURST_LEN};
  assign rd_off_inc = rd_off + {11'd0, BURST_LEN};
  assign wr_wrap    = wr_off_inc >= FRAME_WORDS;
  assign rd_wrap    = rd_off_inc >= FRAME_WORDS;

  assign rd_sel_buf    = rd_clr ? full_buf : rd_buf;
  assign wr_start_addr = (wr_buf ? BANK1_BASE : 21'd0) + (wr_clr ? 21'd0 : wr_off);
  assign rd_start_addr = (rd_sel_buf ? BANK1_BASE : 21'd0) + (rd_clr ? 21'd0 : rd_off);

  // Handshake: sdram_*_req rises on burst entry and holds until the
  // BURST_LEN-th ack of the same type; acks while idle or of the other type are dropped.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sdram_wr_addr <= '0;
      sdram_rd_addr <= '0;
      ack_cnt       <= '0;
      wr_off        <= '0;
      rd_off        <= '0;
      wr_buf        <= 1'b0;
      rd_buf        <= 1'b1;
      full_buf      <= 1'b1;
      wr_pend       <= 1'b0;
      rd_pend       <= 1'b0;
      last_wr       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_clr) begin
            wr_off  <= '0;
            wr_pend <= 1'b0;
          end
          if (rd_clr) begin
            rd_off  <= '0;
            rd_pend <= 1'b0;
            rd_buf  <= full_buf;
          end
          if (init_end && (wr_need || rd_need)) begin
            ack_cnt <= '0;
            busy    <= 1'b1;
            if (pick_wr) begin
              state         <= WR;
              sdram_wr_req  <= 1'b1;
              sdram_wr_addr <= wr_start_addr;
              last_wr       <= 1'b1;
            end else begin
              state         <= RD;
              sdram_rd_req  <= 1'b1;
              sdram_rd_addr <= rd_start_addr;
              last_wr       <= 1'b0;
            end
          end
        end

        WR: begin
          if (wr_frame_start) wr_pend <= 1'b1;
          if (rd_frame_start) rd_pend <= 1'b1;
          if (sdram_wr_ack) begin
            if (last_cnt) begin
              state        <= IDLE;
              sdram_wr_req <= 1'b0;
              busy         <= 1'b0;
              ack_cnt      <= '0;
              if (wr_clr) begin
                wr_off  <= '0;
                wr_pend <= 1'b0;
              end else if (wr_wrap) begin
                // Finished frame becomes the newest complete one for the reader.
                wr_off   <= '0;
                wr_buf   <= ~wr_buf;
                full_buf <= wr_buf;
                rd_buf   <= wr_buf;
              end else begin
                wr_off <= wr_off_inc;
              end
            end else begin
              ack_cnt <= ack_cnt + 11'd1;
            end
          end
        end

        RD: begin
          if (wr_frame_start) wr_pend <= 1'b1;
          if (rd_frame_start) rd_pend <= 1'b1;
          if (sdram_rd_ack) begin
            if (last_cnt) begin
              state        <= IDLE;
              sdram_rd_req <= 1'b0;
              busy         <= 1'b0;
              ack_cnt      <= '0;
              if (rd_clr) begin
                rd_off  <= '0;
                rd_pend <= 1'b0;
                rd_buf  <= full_buf;
              end else if (rd_wrap) begin
                rd_off <= '0;
                rd_buf <= full_buf;
              end else begin
                rd_off <= rd_off_inc;
              end
            end else begin
              ack_cnt <= ack_cnt + 11'd1;
            end
          end
        end

        default: begin
          state        <= IDLE;
          sdram_wr_req <= 1'b0;
          sdram_rd_req <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
